// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: sequential shift-and-add multiplier.
// One shared WIDTH+1-bit adder row retires one multiplier bit per clock;
// a start/busy/done handshake wraps the iteration.
// Optional build macro SEQ_MULT_SIGNED_EN adds a signed_mode input that
// selects two's-complement operands per operation.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     m_q;
  logic [WIDTH-1:0]     acc_hi_q;
  logic [WIDTH-1:0]     acc_lo_q;
  logic [CNT_W-1:0]     counter_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH:0]       hi_ext;
  logic [WIDTH:0]       m_ext;
  logic [WIDTH:0]       sum_ext;
  logic [2*WIDTH-1:0]   shifted_d;
  logic                 last_step;

`ifdef SEQ_MULT_SIGNED_EN
  logic                 signed_q;
`endif

  assign last_step = (counter_q == CNT_W'(WIDTH - 1));

  // One iteration of the adder row: conditional add (or, for the negative
  // MSB weight in signed mode, subtract) followed by a right shift.
  always_comb begin
    hi_ext  = {1'b0, acc_hi_q};
    m_ext   = {1'b0, m_q};
`ifdef SEQ_MULT_SIGNED_EN
    if (signed_q) begin
      // Sign-extend so the bit shifted into the top is the sign of the sum.
      hi_ext = {acc_hi_q[WIDTH-1], acc_hi_q};
      m_ext  = {m_q[WIDTH-1], m_q};
    end
`endif
    sum_ext = hi_ext;
    if (acc_lo_q[0]) begin
`ifdef SEQ_MULT_SIGNED_EN
      if (signed_q && last_step) begin
        sum_ext = hi_ext - m_ext;
      end else begin
        sum_ext = hi_ext + m_ext;
      end
`else
      sum_ext = hi_ext + m_ext;
`endif
    end
    shifted_d = {sum_ext, acc_lo_q[WIDTH-1:1]};
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      counter_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      signed_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q       <= m;
            acc_hi_q  <= '0;
            acc_lo_q  <= q;
            counter_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
`ifdef SEQ_MULT_SIGNED_EN
            signed_q  <= signed_mode;
`endif
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_hi_q  <= shifted_d[2*WIDTH-1:WIDTH];
          acc_lo_q  <= shifted_d[WIDTH-1:0];
          counter_q <= counter_q + CNT_W'(1);
          if (last_step) begin
            // product only ever sees the completed accumulator.
            product_q <= shifted_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed testbench for seq_shift_add_multiplier at WIDTH=4.
// Signed-mode vectors are applied when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_shift_add_multiplier;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   q;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
`ifdef SEQ_MULT_SIGNED_EN
  logic               signed_mode;
`endif

  int vectors;
  int miscompares;

  seq_shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .m          (m),
    .q          (q),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full transaction: accept, WIDTH edges of latency, done pulse, hold.
  task automatic run_mul(input string tag, input logic [3:0] mv, input logic [3:0] qv,
                         input logic [7:0] exp);
    start = 1'b1; m = mv; q = qv;
    tick();
    chk({tag, ".busy0"}, 32'(busy), 32'd1);
    start = 1'b0; m = ~mv; q = ~qv;
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      chk({tag, ".run"}, {30'd0, busy, done}, 32'b10);
    end
    tick();
    chk({tag, ".done"}, {30'd0, busy, done}, 32'b01);
    chk({tag, ".prod"}, 32'(product), 32'(exp));
    tick();
    chk({tag, ".after"}, {22'd0, busy, done, product}, {22'd0, 2'b00, exp});
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; m = '0; q = '0;
`ifdef SEQ_MULT_SIGNED_EN
    signed_mode = 1'b0;
`endif
    tick();
    tick();
    chk("reset", {22'd0, busy, done, product}, 32'd0);
    // Reset beats a simultaneous start.
    start = 1'b1; m = 4'd3; q = 4'd3;
    tick();
    chk("rst_vs_start", {22'd0, busy, done, product}, 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();

    run_mul("3x5", 4'd3, 4'd5, 8'h0F);
    run_mul("15x15", 4'd15, 4'd15, 8'hE1);
    run_mul("0x9", 4'd0, 4'd9, 8'h00);

    // Back-to-back with start held high; second operands arrive in DONE.
    start = 1'b1; m = 4'd2; q = 4'd3;
    tick();
    m = 4'd5; q = 4'd5;
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      chk("b2b.run1", {30'd0, busy, done}, 32'b10);
    end
    tick();
    chk("b2b.done1", {22'd0, busy, done, product}, {22'd0, 2'b01, 8'd6});
    m = 4'd7; q = 4'd6;
    tick();
    chk("b2b.accept2", {22'd0, busy, done, product}, {22'd0, 2'b10, 8'd6});
    start = 1'b0; m = 4'd1; q = 4'd1;
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      chk("b2b.run2", {30'd0, busy, done}, 32'b10);
    end
    tick();
    chk("b2b.done2", {22'd0, busy, done, product}, {22'd0, 2'b01, 8'd42});
    tick();
    chk("b2b.after", {30'd0, busy, done}, 32'd0);

    // start pulsed mid-RUN is ignored.
    start = 1'b1; m = 4'd3; q = 4'd3;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; m = 4'd15; q = 4'd15;
    tick();
    start = 1'b0;
    tick();
    chk("ign.run", {30'd0, busy, done}, 32'b10);
    tick();
    chk("ign.done", {22'd0, busy, done, product}, {22'd0, 2'b01, 8'd9});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ign.quiet", {22'd0, busy, done, product}, {22'd0, 2'b00, 8'd9});
    end

    // Reset during RUN abandons the operation and clears product.
    start = 1'b1; m = 4'd5; q = 4'd6;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rstrun", {22'd0, busy, done, product}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < WIDTH + 1; i++) begin
      tick();
      chk("rstrun.quiet", {22'd0, busy, done, product}, 32'd0);
    end
    run_mul("5x6", 4'd5, 4'd6, 8'h1E);

`ifdef SEQ_MULT_SIGNED_EN
    signed_mode = 1'b1;
    run_mul("s.-8x7", 4'b1000, 4'b0111, 8'hC8);
    run_mul("s.-1x-1", 4'b1111, 4'b1111, 8'h01);
    signed_mode = 1'b0;
    run_mul("u.8x7", 4'd8, 4'd7, 8'h38);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
Parametrised sequential N-bit multiplier. It is the time-multiplexed successor to the first-row array multiplier cell. One shared WIDTH-bit adder row, one partial product per clock, in place of a full combinational cell array. A start/busy/done handshake lets it sit behind a control FSM in the N-bit multiplier datapath. Area stays constant as WIDTH grows.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only when busy=0
m  input  WIDTH  multiplicand; captured on the accepting edge
q  input  WIDTH  multiplier; captured on the accepting edge
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse; product valid from this cycle onward
product  output  2*WIDTH  result; held stable until the next accepted start

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at an edge: state<=IDLE, busy=0, done=0, product=0, counter=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch m into M_r, load acc_hi=0, load acc_lo=q, counter=0, go to RUN.
  - busy goes 1 on that edge.
- RUN, each edge:
  - If acc_lo[0]=1: {carry, sum} = acc_hi + M_r, using a WIDTH+1-bit add. Otherwise sum = acc_hi with carry=0.
  - Shift right one place: {acc_hi, acc_lo} <= {carry, sum, acc_lo[WIDTH-1:1]}.
  - counter increments.
  - On the edge where counter reaches WIDTH-1, the final step completes. product <= the shifted accumulator, state -> DONE, done=1, busy=0.
- Latency: done is high exactly WIDTH edges after the accepting edge. Throughput is one result per WIDTH+1 cycles.
- DONE:
  - Lasts one cycle, then returns to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE. Operands are latched, state goes to RUN, and done still pulses only that one cycle.
- While busy:
  - start is ignored.
  - m and q may change freely with no effect on the result.
- product:
  - Updates only on the DONE transition. It is never a partial value.
  - Retains its value across IDLE and RUN until the next completion.
- Arithmetic: unsigned by default. The full 2*WIDTH-bit result never overflows. Maximum is (2^WIDTH-1)^2.
- Boundary conditions:
  - m=0 or q=0: product=0 with full latency. No early termination.
  - rst asserted during RUN: the operation is abandoned. No done pulse; product clears to 0.
  - rst and start high on the same edge: reset wins.

Optional Feature:
Macro: SEQ_MULT_SIGNED_EN
- Defined:
  - Adds port signed_mode (input, 1 bit), latched alongside the operands at start.
  - When latched signed_mode=1, m and q are two's complement.
  - Adder and carry are sign-extended: the shift-in bit is the sign of acc_hi+M_r, not the carry.
  - On the final step, where the q MSB weight is negative, M_r is subtracted instead of added.
  - Latency is unchanged. signed_mode=0 behaves exactly as the unsigned core.
- Undefined: the port is absent and the operation is unsigned only. The logic is not synthesised.

Test Plan:
1. WIDTH=4, rst 2 cycles, then start with m=3, q=5 -> done pulses 4 edges after accept, product=8'h0F, busy low in the done cycle.
2. WIDTH=4, m=15, q=15 -> product=8'hE1 (225); then m=0, q=9 -> product=8'h00 after full 4-cycle latency.
3. Back-to-back: start held high, m=2 q=3, then m=7 q=6 presented in the DONE cycle -> two done pulses 5 cycles apart, product=6 then 42. Operand changes during RUN are ignored.
4. start pulsed mid-RUN with different operands -> ignored; the original result is delivered and no extra done appears.
5. rst=1 on RUN cycle 2 -> next cycle busy=0, product=0, no done pulse. A new start afterwards completes normally.
6. With SEQ_MULT_SIGNED_EN, WIDTH=4, signed_mode=1:
   - m=4'b1000 (-8), q=4'b0111 (7) -> product=8'hC8 (-56).
   - m=-1, q=-1 -> 8'h01.
   - With signed_mode=0, m=8, q=7 -> 8'h38.
